demux_stream: RTL and testbench
===============================

DEMUX_STREAM -- requirements
Module: demux_stream

Interface
REQ-001 The block SHALL have parameter N_OUT, default 16, meaning the number of output channels (2..16).
REQ-002 The block SHALL have parameter DATA_W, default 8, meaning the width of each data word.
REQ-003 The block SHALL derive SEL_W = clog2(N_OUT) and SHALL NOT expose it as an overridable parameter.
REQ-004 The block SHALL have port clk, input, 1, meaning the single clock; all state SHALL update on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1, meaning the asynchronous, active-low reset.
REQ-006 The block SHALL have port in_valid, input, 1, meaning the upstream word is valid.
REQ-007 The block SHALL have port in_ready, output, 1, meaning the block accepts the word this cycle.
REQ-008 The block SHALL have port in_data, input, DATA_W, meaning the upstream word.
REQ-009 The block SHALL have port in_sel, input, SEL_W, meaning the destination channel index.
REQ-010 The block SHALL have port out_valid, output, N_OUT, meaning per-channel valid, with bit k for channel k.
REQ-011 The block SHALL have port out_ready, input, N_OUT, meaning per-channel downstream ready.
REQ-012 The block SHALL have port out_data, output, N_OUT*DATA_W, meaning flattened per-channel data, with channel k at bits [k*DATA_W +: DATA_W].
REQ-013 The block SHALL have port sel_err, output, 1, meaning a one-cycle pulse after an out-of-range word is dropped.

Function
REQ-014 Each channel SHALL hold a one-entry slot with states EMPTY and FULL; out_valid[k] SHALL equal (state_k == FULL).
REQ-015 An input transfer SHALL occur when in_valid && in_ready; an output transfer on channel k SHALL occur when out_valid[k] && out_ready[k].
REQ-016 For in_sel < N_OUT, in_ready SHALL equal (slot[in_sel] EMPTY) || out_ready[in_sel], combinationally, with no dependence on in_valid.
REQ-017 An accepted word SHALL appear on out_data of channel in_sel with out_valid high on the next cycle, giving 1-cycle latency.
REQ-018 A channel SHALL transition EMPTY->FULL on an input transfer, FULL->EMPTY on an output transfer without an input transfer, and remain FULL, loading new data, on a simultaneous input and output transfer.
REQ-019 out_data[k] SHALL hold stable while out_valid[k] is high and out_ready[k] is low.
REQ-020 A full or stalled channel SHALL NOT block traffic to any other channel.
REQ-021 For in_sel >= N_OUT, which is possible only when N_OUT is not a power of two, in_ready SHALL be 1, the word SHALL be discarded, and sel_err SHALL pulse high for exactly one cycle on the following cycle.
REQ-022 in_ready is only required to be stable when in_valid is high; the block SHALL NOT require in_sel or in_data to be held when in_valid is low.

Reset
REQ-023 Asserting rst_n low SHALL immediately force all slots to EMPTY, out_valid to 0, sel_err to 0, and the sequence counter to 0, regardless of clk.
REQ-024 After reset, out_data contents SHALL be don't-care; the implementation SHALL NOT require resetting them.
REQ-025 Reset asserted mid-transfer SHALL discard all held words, and no word SHALL be emitted after deassertion until a new input transfer occurs.
REQ-026 Reset deassertion SHALL be usable asynchronously; the first transfer SHALL be accepted no earlier than the first rising clk edge with rst_n high.

Configuration
REQ-027 When macro DEMUX_STREAM_SEQ_EN is defined, the block SHALL add input port seq_mode (1 bit) and an internal SEL_W-bit sequence counter.
REQ-028 With DEMUX_STREAM_SEQ_EN defined and seq_mode=1, the destination SHALL be the counter value and in_sel SHALL be ignored.
REQ-029 In sequence mode, the counter SHALL increment on each input transfer, wrapping from N_OUT-1 to 0, and SHALL never take an out-of-range value.
REQ-030 In sequence mode with seq_mode=0, the block SHALL behave as REQ-016..REQ-021, and the counter SHALL hold its value.
REQ-031 With DEMUX_STREAM_SEQ_EN undefined, port seq_mode and the counter SHALL NOT exist, and behaviour SHALL be exactly REQ-014..REQ-026.

Structure
REQ-032 Package demux_pkg SHALL hold the slot-state typedef (EMPTY/FULL) and the default N_OUT/DATA_W constants.
REQ-033 Each channel slot SHALL be one instance of sub-module demux_slot (state, data register, load/drain logic), generated N_OUT times.

Verification
REQ-034 A bench SHALL cover basic routing: N_OUT=16; send 0xA5 with sel=3 while all out_ready=1 -> out_valid=0x0008 and channel 3 data=0xA5 on the next cycle only.
REQ-035 A bench SHALL cover backpressure: out_ready[5]=0; send 0x11 then 0x22 to sel=5 -> second word stalls with in_ready=0, channel 5 holds 0x11; raise out_ready[5] -> 0x22 is accepted that same cycle and appears next cycle.
REQ-036 A bench SHALL cover channel isolation: channel 2 FULL and stalled; send 0x33 to sel=7 -> accepted immediately, and channel 7 is valid next cycle.
REQ-037 A bench SHALL cover out-of-range select: N_OUT=12; send sel=13 -> in_ready=1, no out_valid change, sel_err=1 for one cycle.
REQ-038 A bench SHALL cover reset mid-operation: fill channels 0, 1, and 15, then pull rst_n low between clock edges -> out_valid=0 immediately; after release, nothing is emitted without new input.
REQ-039 A bench SHALL cover sequence mode with DEMUX_STREAM_SEQ_EN defined: seq_mode=1 with 17 words sent, all ready -> channels 0..15 then 0 receive words in order, with in_sel ignored.

Source files
------------

// File: rtl/demux_pkg.sv
// demux_pkg: shared types and default sizing for the demux_stream slice.
// Holds the one-entry slot state encoding used by every output channel.
package demux_pkg;

    // Default number of output channels and default data word width.
    localparam int DEFAULT_N_OUT  = 16;
    localparam int DEFAULT_DATA_W = 8;

    // State of one channel's single-entry holding slot.
    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_e;

    // True when the slot currently presents a word downstream.
    function automatic logic slot_is_full(input slot_state_e state);
        return (state == SLOT_FULL);
    endfunction

endpackage

// File: rtl/demux_slot.sv
// demux_slot: one output channel of demux_stream.
// Holds at most one word; accepts a new word when empty or when the
// held word is being drained in the same cycle (pass-through refill).
module demux_slot
    import demux_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_load,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_ready,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_data,
    output logic              o_can_load
);

    slot_state_e       r_state;
    logic [DATA_W-1:0] r_data;
    logic              w_drain;

    // An output transfer happens only while a word is actually held.
    assign w_drain    = slot_is_full(r_state) && i_ready;

    // Room exists if nothing is held or the held word leaves this cycle.
    assign o_can_load = (r_state == SLOT_EMPTY) || i_ready;

    assign o_valid    = slot_is_full(r_state);
    assign o_data     = r_data;

    // Slot occupancy: fill on load, empty on drain without refill.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= SLOT_EMPTY;
        end else begin
            case (r_state)
                SLOT_EMPTY: begin
                    if (i_load) begin
                        r_state <= SLOT_FULL;
                    end else begin
                        r_state <= SLOT_EMPTY;
                    end
                end
                SLOT_FULL: begin
                    if (i_load) begin
                        r_state <= SLOT_FULL;
                    end else if (w_drain) begin
                        r_state <= SLOT_EMPTY;
                    end else begin
                        r_state <= SLOT_FULL;
                    end
                end
                default: begin
                    r_state <= SLOT_EMPTY;
                end
            endcase
        end
    end

    // Data register needs no reset; it is qualified by r_state everywhere.
    always_ff @(posedge clk) begin
        if (i_load) begin
            r_data <= i_data;
        end else begin
            r_data <= r_data;
        end
    end

endmodule

// File: rtl/demux_stream.sv
// demux_stream: routes one valid/ready input stream to N_OUT output
// channels, each backed by an independent one-entry slot so a stalled
// channel never blocks the others. Out-of-range selects are dropped and
// flagged with a one-cycle sel_err pulse.
// Optional feature: define DEMUX_STREAM_SEQ_EN to add the seq_mode input
// and an internal round-robin destination counter.
module demux_stream
    import demux_pkg::*;
#(
    parameter  int N_OUT  = DEFAULT_N_OUT,
    parameter  int DATA_W = DEFAULT_DATA_W,
    localparam int SEL_W  = (N_OUT > 1) ? $clog2(N_OUT) : 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
`ifdef DEMUX_STREAM_SEQ_EN
    input  logic                      seq_mode,
`endif
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [DATA_W-1:0]         in_data,
    input  logic [SEL_W-1:0]          in_sel,
    output logic [N_OUT-1:0]          out_valid,
    input  logic [N_OUT-1:0]          out_ready,
    output logic [N_OUT*DATA_W-1:0]   out_data,
    output logic                      sel_err
);

    localparam int SEL_P1 = SEL_W + 1;

    logic [SEL_W-1:0] w_dest;
    logic             w_in_range;
    logic [N_OUT-1:0] w_hit;
    logic [N_OUT-1:0] w_can_load;
    logic [N_OUT-1:0] w_load;
    logic             w_in_ready;
    logic             w_in_xfer;
    logic             r_sel_err;

`ifdef DEMUX_STREAM_SEQ_EN
    logic [SEL_W-1:0] r_seq_cnt;
    logic [SEL_W-1:0] w_seq_next;

    // Sequence mode overrides the requested channel with the counter.
    assign w_dest = seq_mode ? r_seq_cnt : in_sel;

    // Next counter value wraps at N_OUT so it never leaves the valid range.
    always_comb begin
        w_seq_next = r_seq_cnt;
        if (r_seq_cnt == SEL_W'(N_OUT - 1)) begin
            w_seq_next = {SEL_W{1'b0}};
        end else begin
            w_seq_next = r_seq_cnt + SEL_W'(1);
        end
    end

    // Counter advances only on accepted words while in sequence mode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_seq_cnt <= {SEL_W{1'b0}};
        end else if (seq_mode && w_in_xfer) begin
            r_seq_cnt <= w_seq_next;
        end else begin
            r_seq_cnt <= r_seq_cnt;
        end
    end
`else
    assign w_dest = in_sel;
`endif

    // Only reachable-false when N_OUT is not a power of two.
    assign w_in_range = ({1'b0, w_dest} < SEL_P1'(N_OUT));

    // One-hot decode of the destination channel.
    always_comb begin
        w_hit = {N_OUT{1'b0}};
        for (int k = 0; k < N_OUT; k++) begin
            if (w_dest == SEL_W'(k)) begin
                w_hit[k] = 1'b1;
            end else begin
                w_hit[k] = 1'b0;
            end
        end
    end

    // Ready follows the addressed slot; out-of-range words are always taken.
    always_comb begin
        w_in_ready = 1'b1;
        if (w_in_range) begin
            w_in_ready = |(w_hit & w_can_load);
        end else begin
            w_in_ready = 1'b1;
        end
    end

    assign in_ready  = w_in_ready;
    assign w_in_xfer = in_valid && w_in_ready;
    assign w_load    = w_hit & {N_OUT{w_in_xfer && w_in_range}};

    // Flag a dropped out-of-range word on the cycle after it was taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sel_err <= 1'b0;
        end else begin
            r_sel_err <= w_in_xfer && !w_in_range;
        end
    end

    assign sel_err = r_sel_err;

    // One independent slot per output channel.
    for (genvar g = 0; g < N_OUT; g++) begin : g_slot
        demux_slot #(
            .DATA_W (DATA_W)
        ) u_slot (
            .clk        (clk),
            .rst_n      (rst_n),
            .i_load     (w_load[g]),
            .i_data     (in_data),
            .i_ready    (out_ready[g]),
            .o_valid    (out_valid[g]),
            .o_data     (out_data[g*DATA_W +: DATA_W]),
            .o_can_load (w_can_load[g])
        );
    end

endmodule

// File: tb/tb_demux_stream.sv
// tb_demux_stream: directed self-checking bench for demux_stream.
// Uses a 16-channel instance for routing, backpressure, isolation, reset
// and sequence mode, and a 12-channel instance for out-of-range selects.
module tb_demux_stream;

    logic clk;
    logic rst_n;

    // 16-channel instance signals
    logic         a_in_valid;
    logic         a_in_ready;
    logic [7:0]   a_in_data;
    logic [3:0]   a_in_sel;
    logic [15:0]  a_out_valid;
    logic [15:0]  a_out_ready;
    logic [127:0] a_out_data;
    logic         a_sel_err;
    logic         a_seq_mode;

    // 12-channel instance signals
    logic         b_in_valid;
    logic         b_in_ready;
    logic [7:0]   b_in_data;
    logic [3:0]   b_in_sel;
    logic [11:0]  b_out_valid;
    logic [11:0]  b_out_ready;
    logic [95:0]  b_out_data;
    logic         b_sel_err;
    logic         b_seq_mode;

    int n_total;
    int n_pass;

    demux_stream #(.N_OUT(16), .DATA_W(8)) u_dut16 (
        .clk       (clk),
        .rst_n     (rst_n),
`ifdef DEMUX_STREAM_SEQ_EN
        .seq_mode  (a_seq_mode),
`endif
        .in_valid  (a_in_valid),
        .in_ready  (a_in_ready),
        .in_data   (a_in_data),
        .in_sel    (a_in_sel),
        .out_valid (a_out_valid),
        .out_ready (a_out_ready),
        .out_data  (a_out_data),
        .sel_err   (a_sel_err)
    );

    demux_stream #(.N_OUT(12), .DATA_W(8)) u_dut12 (
        .clk       (clk),
        .rst_n     (rst_n),
`ifdef DEMUX_STREAM_SEQ_EN
        .seq_mode  (b_seq_mode),
`endif
        .in_valid  (b_in_valid),
        .in_ready  (b_in_ready),
        .in_data   (b_in_data),
        .in_sel    (b_in_sel),
        .out_valid (b_out_valid),
        .out_ready (b_out_ready),
        .out_data  (b_out_data),
        .sel_err   (b_sel_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_total     = 0;
        n_pass      = 0;
        rst_n       = 1'b0;
        a_in_valid  = 1'b0;
        a_in_data   = 8'h00;
        a_in_sel    = 4'h0;
        a_out_ready = 16'hFFFF;
        a_seq_mode  = 1'b0;
        b_in_valid  = 1'b0;
        b_in_data   = 8'h00;
        b_in_sel    = 4'h0;
        b_out_ready = 12'hFFF;
        b_seq_mode  = 1'b0;

        // Reset state
        #12;
        chk("reset_out_valid16", 64'(a_out_valid), 64'h0);
        chk("reset_sel_err16", 64'(a_sel_err), 64'h0);
        chk("reset_out_valid12", 64'(b_out_valid), 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Basic routing: 0xA5 to channel 3
        a_in_valid = 1'b1; a_in_sel = 4'd3; a_in_data = 8'hA5;
        #1;
        chk("route_in_ready", 64'(a_in_ready), 64'h1);
        tick();
        a_in_valid = 1'b0;
        chk("route_out_valid", 64'(a_out_valid), 64'h0008);
        chk("route_data3", 64'(a_out_data[31:24]), 64'hA5);
        tick();
        chk("route_one_cycle", 64'(a_out_valid), 64'h0000);
        chk("route_no_sel_err", 64'(a_sel_err), 64'h0);

        // Backpressure on channel 5
        a_out_ready = 16'hFFDF;
        a_in_valid = 1'b1; a_in_sel = 4'd5; a_in_data = 8'h11;
        tick();
        a_in_data = 8'h22;
        #1;
        chk("bp_stall_ready", 64'(a_in_ready), 64'h0);
        chk("bp_valid5", 64'(a_out_valid), 64'h0020);
        chk("bp_hold_11", 64'(a_out_data[47:40]), 64'h11);
        tick();
        chk("bp_still_stalled", 64'(a_in_ready), 64'h0);
        chk("bp_hold_11_again", 64'(a_out_data[47:40]), 64'h11);
        a_out_ready = 16'hFFFF;
        #1;
        chk("bp_release_ready", 64'(a_in_ready), 64'h1);
        tick();
        a_in_valid = 1'b0;
        chk("bp_valid5_22", 64'(a_out_valid), 64'h0020);
        chk("bp_data_22", 64'(a_out_data[47:40]), 64'h22);
        tick();
        chk("bp_drained", 64'(a_out_valid), 64'h0000);

        // Channel isolation: channel 2 stalled full, channel 7 still flows
        a_out_ready = 16'hFFFB;
        a_in_valid = 1'b1; a_in_sel = 4'd2; a_in_data = 8'h44;
        tick();
        a_in_sel = 4'd7; a_in_data = 8'h33;
        #1;
        chk("iso_ready7", 64'(a_in_ready), 64'h1);
        tick();
        a_in_valid = 1'b0;
        chk("iso_valid", 64'(a_out_valid), 64'h0084);
        chk("iso_data7", 64'(a_out_data[63:56]), 64'h33);
        chk("iso_data2", 64'(a_out_data[23:16]), 64'h44);
        a_in_sel = 4'd2;
        #1;
        chk("iso_ready2_blocked", 64'(a_in_ready), 64'h0);
        a_out_ready = 16'hFFFF;
        tick();
        chk("iso_drained", 64'(a_out_valid), 64'h0000);

        // Out-of-range selects on the 12-channel instance
        b_in_valid = 1'b1; b_in_sel = 4'd13; b_in_data = 8'h99;
        #1;
        chk("oor_ready13", 64'(b_in_ready), 64'h1);
        tick();
        b_in_valid = 1'b0;
        chk("oor_sel_err13", 64'(b_sel_err), 64'h1);
        chk("oor_no_valid13", 64'(b_out_valid), 64'h000);
        tick();
        chk("oor_err_one_cycle", 64'(b_sel_err), 64'h0);
        b_in_valid = 1'b1; b_in_sel = 4'd12; b_in_data = 8'h98;
        #1;
        chk("oor_ready12", 64'(b_in_ready), 64'h1);
        tick();
        b_in_valid = 1'b1; b_in_sel = 4'd11; b_in_data = 8'h5A;
        chk("oor_sel_err12", 64'(b_sel_err), 64'h1);
        tick();
        b_in_valid = 1'b0;
        chk("b_route11_valid", 64'(b_out_valid), 64'h800);
        chk("b_route11_data", 64'(b_out_data[95:88]), 64'h5A);
        chk("b_route11_no_err", 64'(b_sel_err), 64'h0);
        tick();

        // Reset mid-operation with channels 0, 1 and 15 full
        a_out_ready = 16'h0000;
        a_in_valid = 1'b1; a_in_sel = 4'd0; a_in_data = 8'h01;
        tick();
        a_in_sel = 4'd1; a_in_data = 8'h02;
        tick();
        a_in_sel = 4'd15; a_in_data = 8'h0F;
        tick();
        a_in_valid = 1'b0;
        chk("rst_filled", 64'(a_out_valid), 64'h8003);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_async_clear", 64'(a_out_valid), 64'h0000);
        chk("rst_async_err", 64'(a_sel_err), 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        a_out_ready = 16'hFFFF;
        tick();
        chk("rst_no_emit1", 64'(a_out_valid), 64'h0000);
        tick();
        chk("rst_no_emit2", 64'(a_out_valid), 64'h0000);

`ifdef DEMUX_STREAM_SEQ_EN
        // Sequence mode: 17 words go to channels 0..15 then 0
        a_seq_mode = 1'b1;
        for (int i = 0; i < 17; i++) begin
            a_in_valid = 1'b1;
            a_in_sel   = 4'(15 - (i % 16));
            a_in_data  = 8'(8'h80 + i);
            #1;
            chk("seq_ready", 64'(a_in_ready), 64'h1);
            tick();
            chk("seq_valid", 64'(a_out_valid), 64'(16'h0001 << (i % 16)));
            chk("seq_data", 64'(a_out_data[(i % 16)*8 +: 8]), 64'(8'h80 + i));
        end
        a_in_valid = 1'b0;
        a_seq_mode = 1'b0;
        tick();
        chk("seq_drained", 64'(a_out_valid), 64'h0000);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    // Global watchdog so the run always terminates.
    initial begin
        #20000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "timeout");
    end

endmodule
